// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces coin sensor lines, then either
// pulses the accepted coin to the vending machine or opens the reject flap.
`default_nettype none

module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REJECT_HOLD     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] coin_raw,
    input  logic       accept_en,
    output logic [3:0] coin_insert,
    output logic       reject_gate,
    output logic [6:0] coin_value,
    output logic [7:0] coin_count,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_DEBOUNCE     = 3'd1,
        S_ACCEPT       = 3'd2,
        S_REJECT       = 3'd3,
        S_WAIT_RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] C_DEB  = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] C_HOLD = 8'(REJECT_HOLD);

    state_t     state_q, state_d;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] insert_q, insert_d;
    logic       reject_q, reject_d;
    logic [6:0] value_q, value_d;
    logic [7:0] count_q, count_d;
    logic       fault_q, fault_d;

    logic [3:0] w_sample;
    logic       w_onehot;
    logic [6:0] w_cents;

    assign w_sample = sync2_q;
    assign w_onehot = (cap_q != 4'd0) && ((cap_q & (cap_q - 4'd1)) == 4'd0);

    always_comb begin
        w_cents = value_q;
        case (cap_q)
            4'b0001: w_cents = 7'd10;
            4'b0010: w_cents = 7'd20;
            4'b0100: w_cents = 7'd50;
            4'b1000: w_cents = 7'd100;
            default: w_cents = value_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        cap_d    = cap_q;
        insert_d = 4'd0;
        reject_d = reject_q;
        value_d  = value_q;
        count_d  = count_q;
        fault_d  = fault_q;

        case (state_q)
            S_IDLE: begin
                if (w_sample != 4'd0) begin
                    state_d = S_DEBOUNCE;
                    cap_d   = w_sample;
                    cnt_d   = 4'd1;
                end
            end
            S_DEBOUNCE: begin
                if (w_sample == 4'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (w_sample != cap_q) begin
                    cap_d = w_sample;
                    cnt_d = 4'd1;
                end else if ((cnt_q + 4'd1) == C_DEB) begin
                    // Decision edge: accept_en is only looked at here.
                    cnt_d = 4'd0;
                    if (w_onehot && accept_en) begin
                        state_d  = S_ACCEPT;
                        insert_d = cap_q;
                        value_d  = w_cents;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        state_d  = S_REJECT;
                        reject_d = 1'b1;
                        hold_d   = 8'd1;
                        if (!w_onehot) begin
                            fault_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCEPT: begin
                state_d = S_WAIT_RELEASE;
                cnt_d   = 4'd0;
            end
            S_REJECT: begin
                if (hold_q == C_HOLD) begin
                    state_d  = S_WAIT_RELEASE;
                    reject_d = 1'b0;
                    hold_d   = 8'd0;
                    cnt_d    = 4'd0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_WAIT_RELEASE: begin
                // The coin must be seen gone for a full debounce window.
                if (w_sample != 4'd0) begin
                    cnt_d = 4'd0;
                end else if ((cnt_q + 4'd1) == C_DEB) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 4'd0;
            sync2_q  <= 4'd0;
            cnt_q    <= 4'd0;
            hold_q   <= 8'd0;
            cap_q    <= 4'd0;
            insert_q <= 4'd0;
            reject_q <= 1'b0;
            value_q  <= 7'd0;
            count_q  <= 8'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= coin_raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            cap_q    <= cap_d;
            insert_q <= insert_d;
            reject_q <= reject_d;
            value_q  <= value_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    assign coin_insert = insert_q;
    assign reject_gate = reject_q;
    assign coin_value  = value_q;
    assign coin_count  = count_q;
    assign fault       = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: scoreboard bench with a run-length reference model of
// the coin acceptor; directed scenarios followed by randomised traffic.
`default_nettype none

module tb_coin_acceptor;

    localparam int N = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] coin_raw;
    logic       accept_en;
    logic [3:0] coin_insert;
    logic       reject_gate;
    logic [6:0] coin_value;
    logic [7:0] coin_count;
    logic       fault;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(N), .REJECT_HOLD(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_raw    (coin_raw),
        .accept_en   (accept_en),
        .coin_insert (coin_insert),
        .reject_gate (reject_gate),
        .coin_value  (coin_value),
        .coin_count  (coin_count),
        .fault       (fault)
    );

    // kind 0 = accepted pulse, kind 1 = rejection
    typedef struct {
        int         kind;
        logic [3:0] coin;
        int         cyc;
        int         value;
        int         count;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int cents(input logic [3:0] c);
        case (c)
            4'b0001: return 10;
            4'b0010: return 20;
            4'b0100: return 50;
            4'b1000: return 100;
            default: return 0;
        endcase
    endfunction

    // Reference model: tracks the run length of identical synchronised samples;
    // a coin is judged when a nonzero run reaches N, then the machine is busy
    // until the sensor has read empty for N samples after the action finishes.
    int         k;
    logic [3:0] d1, d2;
    bit         m_busy;
    int         skip, zrun, run_len;
    logic [3:0] run_val;
    int         m_count;
    bit         m_fault;

    always @(posedge clk) begin
        if (!reset) begin
            k = 0; d1 = 4'd0; d2 = 4'd0; m_busy = 0; skip = 0; zrun = 0;
            run_len = 0; run_val = 4'd0; m_count = 0; m_fault = 0;
        end else begin
            logic [3:0] s;
            bit         one;
            k++;
            s  = d2;
            d2 = d1;
            d1 = coin_raw;
            if (!m_busy) begin
                if (s == 4'd0) run_len = 0;
                else if (run_len > 0 && s == run_val) run_len++;
                else begin
                    run_val = s;
                    run_len = 1;
                end
                if (run_len == N) begin
                    one = ($countones(run_val) == 1);
                    if (one && accept_en) begin
                        if (m_count < 255) m_count++;
                        q.push_back('{0, run_val, k, cents(run_val), m_count});
                        skip = 1;
                    end else begin
                        if (!one) m_fault = 1;
                        q.push_back('{1, run_val, k, 0, 0});
                        skip = H;
                    end
                    m_busy = 1; zrun = 0; run_len = 0;
                end
            end else if (skip > 0) begin
                skip--;
            end else begin
                if (s == 4'd0) zrun++;
                else zrun = 0;
                if (zrun == N) begin
                    m_busy = 0;
                    zrun = 0;
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows a pulse or opens the flap.
    ev_t me;
    bit  prev_gate;
    int  rej_w;

    always @(negedge clk) begin
        if (!reset) begin
            prev_gate = 0;
            rej_w = 0;
        end else begin
            if (coin_insert != 4'd0) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got coin_insert=%b, expected none", coin_insert);
                end else begin
                    me = q.pop_front();
                    chk("pulse_kind", 0, me.kind);
                    chk("pulse_coin", int'(coin_insert), int'(me.coin));
                    chk("pulse_cycle", k, me.cyc);
                    chk("pulse_value", int'(coin_value), me.value);
                    chk("pulse_count", int'(coin_count), me.count);
                end
            end
            if (reject_gate && !prev_gate) begin
                rej_w = 1;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_reject: got reject_gate=1, expected 0");
                end else begin
                    me = q.pop_front();
                    chk("reject_kind", 1, me.kind);
                    chk("reject_cycle", k, me.cyc);
                end
            end else if (reject_gate) begin
                rej_w++;
            end else if (prev_gate) begin
                chk("reject_width", rej_w, H);
            end
            prev_gate = reject_gate;
        end
    end

    task automatic hold(input logic [3:0] r, input int n);
        repeat (n) begin
            @(negedge clk);
            coin_raw = r;
        end
    endtask

    task automatic hold_rand(input logic [3:0] r, input int n);
        repeat (n) begin
            @(negedge clk);
            coin_raw  = r;
            accept_en = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        reset = 1'b1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_coin_insert"}, int'(coin_insert), 0);
        chk({tag, "_reject_gate"}, int'(reject_gate), 0);
        chk({tag, "_coin_value"},  int'(coin_value), 0);
        chk({tag, "_coin_count"},  int'(coin_count), 0);
        chk({tag, "_fault"},       int'(fault), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] c;
        bit         seen;
        coin_raw  = 4'd0;
        accept_en = 1'b1;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;

        // single $1 coin
        hold(4'b1000, 10);
        hold(4'b0000, 8);
        chk("dollar_value", int'(coin_value), 100);
        chk("dollar_count", int'(coin_count), 1);

        // short glitch is dropped
        hold(4'b0001, 3);
        hold(4'b0000, 8);
        chk("glitch_count", int'(coin_count), 1);
        chk("glitch_gate", int'(reject_gate), 0);

        // multi-coin rejection and sticky fault
        hold(4'b0110, 20);
        hold(4'b0000, 8);
        chk("multi_fault", int'(fault), 1);
        hold(4'b0000, 10);
        chk("multi_fault_sticky", int'(fault), 1);
        chk("multi_count", int'(coin_count), 1);
        do_reset();
        chk("fault_cleared", int'(fault), 0);

        // disabled acceptance, then enable with the coin still held
        accept_en = 1'b0;
        hold(4'b0100, 12);
        accept_en = 1'b1;
        hold(4'b0100, 15);
        chk("disabled_fault", int'(fault), 0);
        chk("disabled_count", int'(coin_count), 0);
        hold(4'b0000, 8);
        hold(4'b0100, 8);
        hold(4'b0000, 8);
        chk("reinsert_count", int'(coin_count), 1);
        chk("reinsert_value", int'(coin_value), 50);

        // reset in the third cycle of a rejection, coin held through release
        accept_en = 1'b0;
        @(negedge clk);
        coin_raw = 4'b0010;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (reject_gate) seen = 1;
        end
        chk("reject_seen", int'(seen), 1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_zero_outputs("async");
        accept_en = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
        reset = 1'b1;
        hold(4'b0010, 10);
        hold(4'b0000, 8);
        chk("post_reset_count", int'(coin_count), 1);
        chk("post_reset_value", int'(coin_value), 20);

        // saturation of the accepted-coin total
        do_reset();
        for (int i = 0; i < 255; i++) begin
            hold(4'b0001, 5);
            hold(4'b0000, 6);
        end
        chk("sat_count_255", int'(coin_count), 255);
        hold(4'b0001, 5);
        hold(4'b0000, 6);
        chk("sat_count_hold", int'(coin_count), 255);

        // randomised traffic
        do_reset();
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    c = 4'b0001;
                2, 3:    c = 4'b0010;
                4, 5:    c = 4'b0100;
                6, 7:    c = 4'b1000;
                default: c = 4'($urandom_range(1, 15));
            endcase
            hold_rand(c, $urandom_range(1, 12));
            if ($urandom_range(0, 4) == 0) hold_rand(4'($urandom_range(1, 15)), $urandom_range(1, 3));
            hold_rand(4'b0000, $urandom_range(0, 9));
        end
        hold(4'b0000, 30);
        chk("queue_drained", q.size(), 0);
        chk("final_count", int'(coin_count), m_count);
        chk("final_fault", int'(fault), int'(m_fault));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
